// File: rtl/timestamp_timer.sv
// timestamp_timer: prescaled timestamp counter with wrap/saturate overflow
// and independent valid/ack capture channels for event time stamping.
module timestamp_timer #(
    parameter int TIME_BITS           = 32,
    parameter int CLK_CYCLES_PER_TICK = 100,
    parameter int SATURATE            = 0,
    parameter int NUM_CAPTURE         = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic                             clear,
    input  logic [NUM_CAPTURE-1:0]           capture,
    input  logic [NUM_CAPTURE-1:0]           cap_ack,
    output logic [TIME_BITS-1:0]             time_out,
    output logic                             tick,
    output logic                             overflow,
    output logic [NUM_CAPTURE*TIME_BITS-1:0] cap_time,
    output logic [NUM_CAPTURE-1:0]           cap_valid,
    output logic [NUM_CAPTURE-1:0]           cap_overrun
);
    localparam int PW = CLK_CYCLES_PER_TICK > 1 ? $clog2(CLK_CYCLES_PER_TICK) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_CYCLES_PER_TICK - 1);

    logic [PW-1:0]                    presc_q, presc_d;
    logic [TIME_BITS-1:0]             time_q, time_d;
    logic                             tick_q, tick_d, ovf_q, ovf_d, sat_q, sat_d;
    logic [NUM_CAPTURE*TIME_BITS-1:0] cap_time_q, cap_time_d;
    logic [NUM_CAPTURE-1:0]           cap_valid_q, cap_valid_d, cap_overrun_q, cap_overrun_d;
    logic                             last;

    assign last = presc_q == PRESC_LAST;

    always_comb begin
        presc_d = presc_q;
        time_d  = time_q;
        sat_d   = sat_q;
        tick_d  = 1'b0;
        ovf_d   = 1'b0;
        if (clear) begin
            presc_d = '0;
            time_d  = '0;
            sat_d   = 1'b0;
        end else if (en) begin
            presc_d = last ? '0 : presc_q + 1'b1;
            // At all-ones in saturate mode the increment is swallowed; overflow fires only on the first attempt.
            if (last && SATURATE != 0 && &time_q) begin
                sat_d = 1'b1;
                ovf_d = !sat_q;
            end else if (last) begin
                time_d = time_q + 1'b1;
                tick_d = 1'b1;
                ovf_d  = &time_q;
            end
        end
    end

    always_comb begin
        cap_time_d    = cap_time_q;
        cap_valid_d   = cap_valid_q;
        cap_overrun_d = cap_overrun_q & ~{NUM_CAPTURE{clear}};
        for (int i = 0; i < NUM_CAPTURE; i++) begin
            if (capture[i] && cap_valid_q[i] && !cap_ack[i]) begin
                cap_overrun_d[i] = 1'b1;
            end else if (capture[i]) begin
                cap_time_d[i*TIME_BITS +: TIME_BITS] = time_q;
                cap_valid_d[i] = 1'b1;
            end else if (cap_ack[i]) begin
                cap_valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            time_q        <= '0;
            tick_q        <= 1'b0;
            ovf_q         <= 1'b0;
            sat_q         <= 1'b0;
            cap_time_q    <= '0;
            cap_valid_q   <= '0;
            cap_overrun_q <= '0;
        end else begin
            presc_q       <= presc_d;
            time_q        <= time_d;
            tick_q        <= tick_d;
            ovf_q         <= ovf_d;
            sat_q         <= sat_d;
            cap_time_q    <= cap_time_d;
            cap_valid_q   <= cap_valid_d;
            cap_overrun_q <= cap_overrun_d;
        end
    end

    assign time_out    = time_q;
    assign tick        = tick_q;
    assign overflow    = ovf_q;
    assign cap_time    = cap_time_q;
    assign cap_valid   = cap_valid_q;
    assign cap_overrun = cap_overrun_q;
endmodule

// File: tb/tb_timestamp_timer.sv
// tb_timestamp_timer: four timer configurations driven by shared directed and
// random stimulus, each checked every cycle against a tick-counting model.
module tb_timestamp_timer;
    logic       clk = 1'b0;
    logic       rst_n, en, clear;
    logic [1:0] capture, cap_ack;
    bit         chk_en = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         ticks;

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : cfg
        localparam int TB  = g == 0 ? 8 : g == 3 ? 3 : 4;
        localparam int CPT = g == 0 ? 4 : g == 3 ? 1 : 2;
        localparam int SAT = g == 2 ? 1 : 0;
        localparam int NC  = g == 3 ? 1 : 2;
        localparam longint MAXV = (longint'(1) << TB) - 1;

        logic [TB-1:0]    time_out;
        logic             tick, overflow;
        logic [NC*TB-1:0] cap_time;
        logic [NC-1:0]    cap_valid, cap_overrun;

        timestamp_timer #(.TIME_BITS(TB), .CLK_CYCLES_PER_TICK(CPT), .SATURATE(SAT), .NUM_CAPTURE(NC)) dut (
            .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
            .capture(capture[NC-1:0]), .cap_ack(cap_ack[NC-1:0]),
            .time_out(time_out), .tick(tick), .overflow(overflow),
            .cap_time(cap_time), .cap_valid(cap_valid), .cap_overrun(cap_overrun)
        );

        // Model: time is the number of completed CPT-cycle periods since clear, wrapped or clamped.
        longint ec = 0, m_time = 0, n;
        bit     m_tick = 0, m_ovf = 0;
        longint m_ct[NC];
        bit     m_cv[NC], m_co[NC];

        initial forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                ec = 0; m_time = 0; m_tick = 0; m_ovf = 0;
                for (int i = 0; i < NC; i++) begin
                    m_ct[i] = 0; m_cv[i] = 0; m_co[i] = 0;
                end
            end else begin
                for (int i = 0; i < NC; i++) begin
                    if (capture[i] && m_cv[i] && !cap_ack[i]) m_co[i] = 1;
                    else begin
                        if (clear) m_co[i] = 0;
                        if (capture[i]) begin
                            m_ct[i] = m_time;
                            m_cv[i] = 1;
                        end else if (cap_ack[i]) m_cv[i] = 0;
                    end
                end
                m_tick = 0;
                m_ovf  = 0;
                if (clear) begin
                    ec = 0; m_time = 0;
                end else if (en) begin
                    ec++;
                    if (ec % CPT == 0) begin
                        n = ec / CPT;
                        if (SAT != 0) begin
                            m_tick = n <= MAXV;
                            m_ovf  = n == MAXV + 1;
                            m_time = n > MAXV ? MAXV : n;
                        end else begin
                            m_time = n % (MAXV + 1);
                            m_tick = 1;
                            m_ovf  = m_time == 0;
                        end
                    end
                end
            end
        end

        always @(negedge clk) if (chk_en) begin
            check($sformatf("c%0d time", g), time_out, m_time);
            check($sformatf("c%0d tick", g), tick, m_tick);
            check($sformatf("c%0d ovf", g), overflow, m_ovf);
            for (int i = 0; i < NC; i++) begin
                check($sformatf("c%0d cap_time%0d", g, i), cap_time[i*TB +: TB], m_ct[i]);
                check($sformatf("c%0d cap_valid%0d", g, i), cap_valid[i], m_cv[i]);
                check($sformatf("c%0d cap_overrun%0d", g, i), cap_overrun[i], m_co[i]);
            end
        end
    end

    initial begin
        rst_n = 1; en = 0; clear = 0; capture = 0; cap_ack = 0;
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        check("reset time", cfg[0].time_out, 0);
        check("reset valid", cfg[0].cap_valid, 0);
        rst_n = 1; en = 1;
        ticks = 0;
        repeat (4) begin @(negedge clk); ticks += int'(cfg[0].tick); end
        check("count 4clk", cfg[0].time_out, 1);
        repeat (16) begin @(negedge clk); ticks += int'(cfg[0].tick); end
        check("count 20clk", cfg[0].time_out, 5);
        check("tick count", ticks, 5);
        check("cpt1 time", cfg[3].time_out, 4);
        check("cpt1 tick", cfg[3].tick, 1);
        repeat (11) @(negedge clk);
        check("pre-wrap", cfg[1].time_out, 15);
        @(negedge clk);
        check("wrap time", cfg[1].time_out, 0);
        check("wrap ovf", cfg[1].overflow, 1);
        check("wrap tick", cfg[1].tick, 1);
        check("sat time", cfg[2].time_out, 15);
        check("sat ovf", cfg[2].overflow, 1);
        check("sat tick", cfg[2].tick, 0);
        repeat (2) @(negedge clk);
        check("sat ovf once", cfg[2].overflow, 0);
        check("sat hold", cfg[2].time_out, 15);
        check("wrap next", cfg[1].time_out, 1);
        clear = 1;
        @(negedge clk);
        clear = 0;
        check("clear time", cfg[0].time_out, 0);
        repeat (14) @(negedge clk);
        check("pre-hold", cfg[0].time_out, 3);
        en = 0;
        repeat (10) begin
            @(negedge clk);
            check("hold time", cfg[0].time_out, 3);
            check("hold tick", cfg[0].tick, 0);
        end
        en = 1;
        @(negedge clk);
        check("reen 1", cfg[0].time_out, 3);
        @(negedge clk);
        check("reen 2", cfg[0].time_out, 4);
        repeat (12) @(negedge clk);
        check("at 7", cfg[0].time_out, 7);
        capture = 2'b01;
        @(negedge clk);
        capture = 0;
        check("cap0 time", cfg[0].cap_time[7:0], 7);
        check("cap0 valid", cfg[0].cap_valid[0], 1);
        capture = 2'b01;
        @(negedge clk);
        capture = 0;
        check("cap0 kept", cfg[0].cap_time[7:0], 7);
        check("cap0 overrun", cfg[0].cap_overrun[0], 1);
        cap_ack = 2'b01;
        @(negedge clk);
        cap_ack = 0;
        check("ack valid", cfg[0].cap_valid[0], 0);
        check("ch1 valid", cfg[0].cap_valid[1], 0);
        check("ch1 overrun", cfg[0].cap_overrun[1], 0);
        repeat (8) @(negedge clk);
        check("at 9", cfg[0].time_out, 9);
        capture = 2'b10;
        @(negedge clk);
        check("cap1 edge", cfg[0].cap_time[15:8], 9);
        check("edge time", cfg[0].time_out, 10);
        cap_ack = 2'b10;
        @(negedge clk);
        check("cap+ack time", cfg[0].cap_time[15:8], 10);
        check("cap+ack valid", cfg[0].cap_valid[1], 1);
        check("cap+ack ovr", cfg[0].cap_overrun[1], 0);
        capture = 2'b11; cap_ack = 0;
        #2 rst_n = 0;
        #1;
        check("arst time", cfg[0].time_out, 0);
        check("arst tick", cfg[0].tick, 0);
        check("arst captime", cfg[0].cap_time, 0);
        check("arst valid", cfg[0].cap_valid, 0);
        check("arst overrun", cfg[0].cap_overrun, 0);
        @(negedge clk);
        capture = 0; rst_n = 1;
        repeat (3000) begin
            @(negedge clk);
            en      = $urandom_range(0, 9) != 0;
            clear   = $urandom_range(0, 511) == 0;
            capture = {$urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0};
            cap_ack = {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0};
        end
        @(negedge clk);
        chk_en = 0;
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
